// File: rtl/ir_fetch_queue.sv
// Fetch PC + single-port instruction memory + QUEUE_DEPTH instruction queue feeding decode; first IRValid 2+MEM_LAT edges after FetchEn.
// Backpressure: IRReady low fills the queue, then fetch parks in ISSUE. Optional counters via IR_FETCH_PERF_EN.
module ir_fetch_queue #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LAT     = 1,
    parameter int QUEUE_DEPTH = 2,
    parameter int PC_STEP     = 1,
    parameter int RESET_PC    = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FetchEn,
    input  logic              PCWrite,
    input  logic [ADDR_W-1:0] PCData,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    input  logic              IRReady,
    output logic              IRValid,
    output logic [DATA_W-1:0] IROut,
    output logic [ADDR_W-1:0] IRPC
`ifdef IR_FETCH_PERF_EN
    ,
    output logic [15:0]       StallCycles,
    output logic [15:0]       FetchCount
`endif
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [2:0]       LAT_LAST = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_dat;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] q_dat [QUEUE_DEPTH];
    logic [DATA_W-1:0] q_dat_nxt [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc_nxt [QUEUE_DEPTH];
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              issue, push, pop;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^MemAddr[ADDR_W-1:IDX_W];
    assign IRValid = (cnt != '0);
    assign pop     = IRValid & IRReady & ~PCWrite;

    // Read data is captured at issue; the WAIT cycles only model the latency.
    always_ff @(posedge CLK) begin
        if (MemWrite)
            mem[MemAddr[IDX_W-1:0]] <= MemData;
        if (issue) begin
            rd_dat <= mem[pc[IDX_W-1:0]];
            rd_pc  <= pc;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE:  if (FetchEn) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!FetchEn) begin
                    state_nxt = S_IDLE;
                end else if (!MemWrite && cnt < DEPTH_C) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    push      = 1'b1;
                    state_nxt = FetchEn ? S_ISSUE : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Leaving WAIT on redirect is what discards the in-flight read.
        if (PCWrite) begin
            issue     = 1'b0;
            push      = 1'b0;
            state_nxt = FetchEn ? S_ISSUE : S_IDLE;
        end
    end

    always_comb begin
        q_dat_nxt = q_dat;
        q_pc_nxt  = q_pc;
        cnt_nxt   = cnt;
        if (pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                q_dat_nxt[i] = q_dat[i+1];
                q_pc_nxt[i]  = q_pc[i+1];
            end
            cnt_nxt = cnt - 1'b1;
        end
        if (push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (CNT_W'(i) == cnt_nxt) begin
                    q_dat_nxt[i] = rd_dat;
                    q_pc_nxt[i]  = rd_pc;
                end
            end
            cnt_nxt = cnt_nxt + 1'b1;
        end
        if (PCWrite)
            cnt_nxt = '0;
    end

    always_ff @(posedge CLK) begin
        q_dat <= q_dat_nxt;
        q_pc  <= q_pc_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            pc       <= ADDR_W'(RESET_PC);
            wait_cnt <= '0;
            cnt      <= '0;
            IROut    <= '0;
            IRPC     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (PCWrite)
                pc <= PCData;
            else if (issue)
                pc <= pc + ADDR_W'(PC_STEP);
            if (issue)
                wait_cnt <= LAT_LAST;
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            // Head register holds its last value once the queue drains.
            if (cnt_nxt != '0) begin
                IROut <= q_dat_nxt[0];
                IRPC  <= q_pc_nxt[0];
            end
        end
    end

`ifdef IR_FETCH_PERF_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            StallCycles <= '0;
            FetchCount  <= '0;
        end else begin
            if (FetchEn && !IRValid && StallCycles != 16'hFFFF)
                StallCycles <= StallCycles + 16'd1;
            if (IRValid && IRReady && FetchCount != 16'hFFFF)
                FetchCount <= FetchCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed bench for ir_fetch_queue: expected {instruction, PC} pairs are queued by the stimulus and popped by a monitor.
module tb_ir_fetch_queue;

    typedef struct {
        logic [15:0] dat;
        logic [15:0] pc;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        FetchEn, PCWrite, MemWrite, IRReady;
    logic [15:0] PCData, MemAddr, MemData;
    logic        IRValid;
    logic [15:0] IROut, IRPC;
    logic        FetchEn3;
    logic        IRValid3;
    logic [15:0] IROut3, IRPC3;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;

    ir_fetch_queue u_dut (
        .CLK(CLK), .RST_N(RST_N), .FetchEn(FetchEn), .PCWrite(PCWrite), .PCData(PCData),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData), .IRReady(IRReady),
        .IRValid(IRValid), .IROut(IROut), .IRPC(IRPC)
    );

    ir_fetch_queue #(.MEM_LAT(3)) u_lat3 (
        .CLK(CLK), .RST_N(RST_N), .FetchEn(FetchEn3), .PCWrite(1'b0), .PCData(16'h0000),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData), .IRReady(1'b0),
        .IRValid(IRValid3), .IROut(IROut3), .IRPC(IRPC3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic expect_ir(input logic [15:0] d, input logic [15:0] p);
        exp_t e;
        e.dat = d;
        e.pc  = p;
        sb.push_back(e);
    endtask

    task automatic redirect(input logic [15:0] target);
        PCWrite = 1'b1;
        PCData  = target;
        step(1);
        PCWrite = 1'b0;
    endtask

    task automatic mem_wr(input logic [15:0] a, input logic [15:0] d);
        MemWrite = 1'b1;
        MemAddr  = a;
        MemData  = d;
        step(1);
        MemWrite = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (!IRValid && cycles < 20);
    endtask

    // Every accepted instruction must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N && IRValid && IRReady && !PCWrite) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got IROut=%0d IRPC=0x%0h, required no instruction", IROut, IRPC);
            end else begin
                mon_e = sb.pop_front();
                check("ir_out", 32'(IROut), 32'(mon_e.dat));
                check("ir_pc", 32'(IRPC), 32'(mon_e.pc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; FetchEn = 1'b0; PCWrite = 1'b0; MemWrite = 1'b0; IRReady = 1'b0;
        PCData = '0; MemAddr = '0; MemData = '0; FetchEn3 = 1'b0;
        step(2);
        check("reset_irvalid", 32'(IRValid), 32'd0);
        check("reset_irout", 32'(IROut), 32'd0);
        check("reset_irpc", 32'(IRPC), 32'd0);
        RST_N = 1'b1;
        step(1);
        mem_wr(16'd0, 16'd19);
        mem_wr(16'd1, 16'd20);
        mem_wr(16'd2, 16'd21);
        mem_wr(16'd3, 16'd22);
        mem_wr(16'd1023, 16'd77);

        // Streaming fetch with decode always ready
        expect_ir(16'd19, 16'd0); expect_ir(16'd20, 16'd1);
        expect_ir(16'd21, 16'd2); expect_ir(16'd22, 16'd3);
        IRReady = 1'b1;
        FetchEn = 1'b1;
        wait_valid(n);
        check("first_valid_latency", 32'(n), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            wait_valid(n);
            check("issue_spacing", 32'(n), 32'd2);
            if (k == 3) FetchEn = 1'b0;
        end
        step(3);
        check("stream_drained", 32'(sb.size()), 32'd0);

        // Decode stalled: queue fills to two entries then releases in order
        IRReady = 1'b0;
        FetchEn = 1'b1;
        redirect(16'd0);
        step(8);
        check("full_irvalid", 32'(IRValid), 32'd1);
        check("full_head_dat", 32'(IROut), 32'd19);
        check("full_head_pc", 32'(IRPC), 32'd0);
        expect_ir(16'd19, 16'd0); expect_ir(16'd20, 16'd1); expect_ir(16'd21, 16'd2);
        IRReady = 1'b1;
        step(2);
        FetchEn = 1'b0;
        step(4);
        check("backpressure_drained", 32'(sb.size()), 32'd0);

        // Redirect while a read is in flight and 19 is queued
        IRReady = 1'b0;
        FetchEn = 1'b1;
        redirect(16'd0);
        step(3);
        check("pre_redirect_valid", 32'(IRValid), 32'd1);
        check("pre_redirect_dat", 32'(IROut), 32'd19);
        redirect(16'd3);
        check("redirect_flush_valid", 32'(IRValid), 32'd0);
        expect_ir(16'd22, 16'd3);
        IRReady = 1'b1;
        step(1);
        FetchEn = 1'b0;
        step(3);
        check("redirect_drained", 32'(sb.size()), 32'd0);

        // Memory writes block issue; rewritten word is then fetched
        IRReady = 1'b1;
        FetchEn = 1'b1;
        redirect(16'd1);
        expect_ir(16'd55, 16'd1);
        MemWrite = 1'b1; MemAddr = 16'd1; MemData = 16'd55;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("memwrite_blocks_issue", 32'(IRValid), 32'd0);
        end
        MemWrite = 1'b0;
        step(1);
        FetchEn = 1'b0;
        step(3);
        check("memwrite_drained", 32'(sb.size()), 32'd0);

        // PC wraps from 0xFFFF to 0
        expect_ir(16'd77, 16'hFFFF); expect_ir(16'd19, 16'd0);
        FetchEn = 1'b1;
        redirect(16'hFFFF);
        step(3);
        FetchEn = 1'b0;
        step(3);
        check("wrap_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a read
        IRReady = 1'b0;
        FetchEn = 1'b1;
        redirect(16'd2);
        step(3);
        check("pre_reset_valid", 32'(IRValid), 32'd1);
        RST_N = 1'b0;
        #1;
        check("async_reset_irvalid", 32'(IRValid), 32'd0);
        check("async_reset_irout", 32'(IROut), 32'd0);
        check("async_reset_irpc", 32'(IRPC), 32'd0);
        step(2);
        expect_ir(16'd19, 16'd0);
        IRReady = 1'b1;
        RST_N = 1'b1;
        wait_valid(n);
        check("reset_release_latency", 32'(n), 32'd3);
        FetchEn = 1'b0;
        step(3);
        check("reset_drained", 32'(sb.size()), 32'd0);

        // Three-cycle memory latency instance
        RST_N = 1'b0;
        step(1);
        FetchEn3 = 1'b1;
        RST_N = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!IRValid3 && n < 20);
        check("lat3_latency", 32'(n), 32'd5);
        check("lat3_dat", 32'(IROut3), 32'd19);
        check("lat3_pc", 32'(IRPC3), 32'd0);
        FetchEn3 = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
